multi_key_debounce: RTL and testbench

- Parametrised N-channel key debouncer; successor to the single-channel 10 ms edge-delay block.
- Each channel validates a pin level change held for DEBOUNCE_MS milliseconds, then updates a clean level and emits one-cycle press/release strobes.
- A bounce during the check window aborts that check. The previous block had no abort.
- Sits between raw board key pins (asynchronous) and the control logic.

---
 rtl/key_pkg.sv | 34 +++
 rtl/key_debounce_ch.sv | 166 ++++++++++++++++
 rtl/multi_key_debounce.sv | 78 +++++++
 tb/tb_multi_key_debounce.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the multi-channel key debouncer.
//   - key_state_e : per-channel debounce FSM state
//   - cnt_width() : bits needed to hold the values 0..max_val (never below 1)
//   - tick_div()  : clock cycles per 1 ms tick (never below 1)
// No ports; imported by key_debounce_ch and multi_key_debounce.
// -----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } key_state_e;

    // Width of a counter that must reach max_val without wrapping
    function automatic int cnt_width(input int max_val);
        if (max_val < 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val + 32'sd1);
        end
    endfunction

    // Cycles per millisecond; slow clocks degrade to a tick every cycle
    function automatic int tick_div(input int clk_hz);
        if (clk_hz < 32'sd2000) begin
            return 32'sd1;
        end else begin
            return clk_hz / 32'sd1000;
        end
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One debounce channel: input synchroniser, IDLE/CHECK FSM, millisecond window
// counter and, when KEY_LONG_PRESS_EN is defined, a long-press hold counter.
// Ports:
//   clk           in  system clock
//   rst_n         in  synchronous active-low reset
//   tick          in  1 ms strobe shared by all channels
//   pin           in  raw asynchronous key pin
//   key_out       out debounced level (registered)
//   press_pulse   out 1-cycle strobe when key_out goes to !IDLE_LEVEL
//   release_pulse out 1-cycle strobe when key_out goes to IDLE_LEVEL
//   busy          out channel is checking a candidate change
//   long_pulse    out 1-cycle long-press strobe (0 unless KEY_LONG_PRESS_EN)
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int   DEBOUNCE_MS = 32'sd10,
    parameter int   SYNC_STAGES = 32'sd2,
    parameter logic IDLE_LEVEL  = 1'b1,
    parameter int   LONG_MS     = 32'sd1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin,
    output logic key_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy,
    output logic long_pulse
);

    localparam int              MS_W    = cnt_width(DEBOUNCE_MS);
    localparam logic [MS_W-1:0] MS_ZERO = {MS_W{1'b0}};
    localparam logic [MS_W-1:0] MS_INC  = MS_W'(1'b1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(DEBOUNCE_MS - 32'sd1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   pin_s;
    key_state_e             state_r;
    key_state_e             state_nxt_s;
    logic                   key_r;
    logic                   key_nxt_s;
    logic [MS_W-1:0]        ms_cnt_r;
    logic [MS_W-1:0]        ms_cnt_nxt_s;
    logic                   press_r;
    logic                   press_nxt_s;
    logic                   release_r;
    logic                   release_nxt_s;
    logic                   busy_r;

    assign pin_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous pin; resets to the released level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
        end
    end

    // Next-state logic: a bounce back to the current level always beats an
    // accepting tick arriving in the same cycle
    always_comb begin
        state_nxt_s   = state_r;
        key_nxt_s     = key_r;
        ms_cnt_nxt_s  = ms_cnt_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pin_s != key_r) begin
                    state_nxt_s  = ST_CHECK;
                    ms_cnt_nxt_s = MS_ZERO;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (pin_s == key_r) begin
                    state_nxt_s  = ST_IDLE;
                    ms_cnt_nxt_s = MS_ZERO;
                end else if (tick && (ms_cnt_r == MS_LAST)) begin
                    state_nxt_s  = ST_IDLE;
                    key_nxt_s    = pin_s;
                    ms_cnt_nxt_s = MS_ZERO;
                    if (pin_s == IDLE_LEVEL) begin
                        release_nxt_s = 1'b1;
                    end else begin
                        press_nxt_s   = 1'b1;
                    end
                end else if (tick) begin
                    ms_cnt_nxt_s = ms_cnt_r + MS_INC;
                end else begin
                    ms_cnt_nxt_s = ms_cnt_r;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                ms_cnt_nxt_s = MS_ZERO;
            end
        endcase
    end

    // State, debounced level, window counter and strobe registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            key_r     <= IDLE_LEVEL;
            ms_cnt_r  <= MS_ZERO;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            key_r     <= key_nxt_s;
            ms_cnt_r  <= ms_cnt_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            busy_r    <= (state_nxt_s == ST_CHECK);
        end
    end

    assign key_out       = key_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign busy          = busy_r;

`ifdef KEY_LONG_PRESS_EN
    localparam int                HOLD_W    = cnt_width(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_INC  = HOLD_W'(1'b1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_MS - 32'sd1);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic              long_r;

    // Hold timer: saturating, so the long strobe fires once per press and is
    // re-armed only when the debounced level returns to released
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_r <= HOLD_ZERO;
            long_r     <= 1'b0;
        end else if (key_r == IDLE_LEVEL) begin
            hold_cnt_r <= HOLD_ZERO;
            long_r     <= 1'b0;
        end else if (tick && (hold_cnt_r != HOLD_MAX)) begin
            hold_cnt_r <= hold_cnt_r + HOLD_INC;
            long_r     <= (hold_cnt_r == HOLD_PRE);
        end else begin
            long_r     <= 1'b0;
        end
    end

    assign long_pulse = long_r;
`else
    localparam int unused_long_ms = LONG_MS;

    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_key_debounce.sv
// -----------------------------------------------------------------------------
// multi_key_debounce
// N-channel key debouncer: a free-running 1 ms tick generator shared by
// CH_NUM independent key_debounce_ch instances. A pin change must be held
// for DEBOUNCE_MS ticks; any bounce during the window aborts the check.
// Optional feature macro: KEY_LONG_PRESS_EN (long-press strobe after LONG_MS).
// Ports:
//   CLK           in  system clock
//   RSTn          in  synchronous active-low reset
//   Pin_In        in  [CH_NUM] raw asynchronous key pins
//   Key_Out       out [CH_NUM] debounced levels
//   Press_Pulse   out [CH_NUM] 1-cycle strobe on change to !IDLE_LEVEL
//   Release_Pulse out [CH_NUM] 1-cycle strobe on change to IDLE_LEVEL
//   Busy          out [CH_NUM] channel is checking a candidate change
//   Long_Pulse    out [CH_NUM] 1-cycle long-press strobe (0 when compiled out)
// -----------------------------------------------------------------------------
module multi_key_debounce
    import key_pkg::*;
#(
    parameter int   CH_NUM      = 32'sd4,
    parameter int   CLK_FREQ_HZ = 32'sd50_000_000,
    parameter int   DEBOUNCE_MS = 32'sd10,
    parameter int   SYNC_STAGES = 32'sd2,
    parameter logic IDLE_LEVEL  = 1'b1,
    parameter int   LONG_MS     = 32'sd1000
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [CH_NUM-1:0] Pin_In,
    output logic [CH_NUM-1:0] Key_Out,
    output logic [CH_NUM-1:0] Press_Pulse,
    output logic [CH_NUM-1:0] Release_Pulse,
    output logic [CH_NUM-1:0] Busy,
    output logic [CH_NUM-1:0] Long_Pulse
);

    localparam int               TICK_DIV = tick_div(CLK_FREQ_HZ);
    localparam int               PRE_W    = cnt_width(TICK_DIV - 32'sd1);
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_INC  = PRE_W'(1'b1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 32'sd1);

    logic [PRE_W-1:0] pre_cnt_r;
    logic             tick_s;

    // Millisecond prescaler: wraps on its terminal count, never stalls
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            pre_cnt_r <= PRE_ZERO;
        end else if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_r <= PRE_ZERO;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_INC;
        end
    end

    assign tick_s = (pre_cnt_r == PRE_LAST);

    for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .SYNC_STAGES (SYNC_STAGES),
            .IDLE_LEVEL  (IDLE_LEVEL),
            .LONG_MS     (LONG_MS)
        ) u_ch (
            .clk           (CLK),
            .rst_n         (RSTn),
            .tick          (tick_s),
            .pin           (Pin_In[ch]),
            .key_out       (Key_Out[ch]),
            .press_pulse   (Press_Pulse[ch]),
            .release_pulse (Release_Pulse[ch]),
            .busy          (Busy[ch]),
            .long_pulse    (Long_Pulse[ch])
        );
    end

endmodule

// File: tb/tb_multi_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_multi_key_debounce
// Directed scenarios followed by randomized bouncy pin traffic. A reference
// model expressed in terms of edge numbers and tick arithmetic predicts, per
// clock edge, the debounced levels, busy flags and any strobes; predictions go
// into queues and a separate monitor compares them against the DUT on the
// falling edge. Long-press expectations are active when KEY_LONG_PRESS_EN is
// defined; otherwise Long_Pulse must stay 0.
// -----------------------------------------------------------------------------
module tb_multi_key_debounce;

    localparam int CH     = 4;
    localparam int CLK_HZ = 10_000;
    localparam int DIV    = 10;
    localparam int DEB    = 10;
    localparam int LONG   = 50;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic [CH-1:0] Pin_In;
    logic [CH-1:0] Key_Out;
    logic [CH-1:0] Press_Pulse;
    logic [CH-1:0] Release_Pulse;
    logic [CH-1:0] Busy;
    logic [CH-1:0] Long_Pulse;

    always #5 CLK = ~CLK;

    multi_key_debounce #(
        .CH_NUM      (CH),
        .CLK_FREQ_HZ (CLK_HZ),
        .DEBOUNCE_MS (DEB),
        .SYNC_STAGES (2),
        .IDLE_LEVEL  (1'b1),
        .LONG_MS     (LONG)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .Pin_In        (Pin_In),
        .Key_Out       (Key_Out),
        .Press_Pulse   (Press_Pulse),
        .Release_Pulse (Release_Pulse),
        .Busy          (Busy),
        .Long_Pulse    (Long_Pulse)
    );

    typedef struct {
        int            cyc;
        logic [CH-1:0] key;
        logic [CH-1:0] busy;
    } st_t;

    typedef struct {
        int            cyc;
        logic [CH-1:0] prs;
        logic [CH-1:0] rel;
        logic [CH-1:0] lng;
    } ev_t;

    st_t st_q[$];
    ev_t ev_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: k_m = edges so far, r_m = edge of the last reset
    int            k_m = 0;
    int            r_m = 0;
    logic [CH-1:0] key_m  = '1;
    logic [CH-1:0] pend_m = '0;
    int            ent_m    [CH];
    int            prs_at_m [CH];
    logic [CH-1:0] pin_h1 = '1;
    logic [CH-1:0] pin_h2 = '1;
    bit            rst_h1 = 1'b1;
    bit            rst_h2 = 1'b1;
    logic [CH-1:0] pin_v  = '1;

    // Ticks occur on edges k with (k - r_m) a positive multiple of DIV;
    // this counts those on edges a+1..b
    function automatic int ticks_between(input int a, input int b);
        return (b - r_m) / DIV - (a - r_m) / DIV;
    endfunction

    function automatic void check(input string name, input int cyc,
                                  input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s edge=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endfunction

    // Apply one input vector for one clock edge and predict the result
    task automatic step(input logic [CH-1:0] pin, input logic rstn);
        logic [CH-1:0] s;
        logic [CH-1:0] p;
        logic [CH-1:0] rl;
        logic [CH-1:0] lg;
        bit            tk;
        Pin_In = pin;
        RSTn   = rstn;
        @(posedge CLK);
        #1;
        k_m++;
        p  = '0;
        rl = '0;
        lg = '0;
        // the FSM sees the pin applied two edges earlier, or released level
        // if either of those edges was a reset
        s = (rst_h1 || rst_h2) ? '1 : pin_h2;
        if (!rstn) begin
            key_m  = '1;
            pend_m = '0;
            r_m    = k_m;
        end else begin
            tk = ((k_m - r_m) % DIV) == 0;
            for (int c = 0; c < CH; c++) begin
`ifdef KEY_LONG_PRESS_EN
                if (!key_m[c] && tk && ticks_between(prs_at_m[c], k_m) == LONG)
                    lg[c] = 1'b1;
`endif
                if (pend_m[c]) begin
                    if (s[c] == key_m[c]) begin
                        pend_m[c] = 1'b0;
                    end else if (tk && ticks_between(ent_m[c], k_m) == DEB) begin
                        key_m[c]  = s[c];
                        pend_m[c] = 1'b0;
                        if (s[c]) begin
                            rl[c] = 1'b1;
                        end else begin
                            p[c]        = 1'b1;
                            prs_at_m[c] = k_m;
                        end
                    end
                end else if (s[c] != key_m[c]) begin
                    pend_m[c] = 1'b1;
                    ent_m[c]  = k_m;
                end
            end
        end
        pin_h2 = pin_h1;
        pin_h1 = pin;
        rst_h2 = rst_h1;
        rst_h1 = !rstn;
        st_q.push_back('{k_m, key_m, pend_m});
        if ((p | rl | lg) != '0) ev_q.push_back('{k_m, p, rl, lg});
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(pin_v, 1'b1);
    endtask

    // Drop pin 0 and return it so the bounce reaches the FSM 'off' edges
    // relative to the edge that would accept the press
    task automatic race(input int off);
        int c;
        int e;
        int ka;
        int h;
        c  = k_m + 1;
        e  = c + 2;
        ka = e + 1;
        while (((ka - r_m) % DIV) != 0 || ticks_between(e, ka) < DEB) ka++;
        h = ka + off - 2;
        pin_v[0] = 1'b0;
        while (k_m + 1 < h) step(pin_v, 1'b1);
        pin_v[0] = 1'b1;
        hold(150);
    endtask

    // Monitor: compares DUT outputs with the queued predictions
    initial begin : monitor
        st_t st;
        ev_t ev;
        forever begin
            @(negedge CLK);
            if (st_q.size() != 0) begin
                st = st_q.pop_front();
                check("key_out", st.cyc, 32'(Key_Out), 32'(st.key));
                check("busy", st.cyc, 32'(Busy), 32'(st.busy));
                if (ev_q.size() != 0 && ev_q[0].cyc == st.cyc) begin
                    ev = ev_q.pop_front();
                    check("press_pulse", st.cyc, 32'(Press_Pulse), 32'(ev.prs));
                    check("release_pulse", st.cyc, 32'(Release_Pulse), 32'(ev.rel));
                    check("long_pulse", st.cyc, 32'(Long_Pulse), 32'(ev.lng));
                end else begin
                    check("no_strobe", st.cyc,
                          32'({Press_Pulse, Release_Pulse, Long_Pulse}), 32'd0);
                end
            end
        end
    end

    initial begin : stimulus
        int len;
        int rate;
        bit rst_bit;

        // reset with all pins pressed, then acceptance on every channel
        pin_v = '0;
        for (int i = 0; i < 5; i++) step(pin_v, 1'b0);
        hold(120);
        pin_v = '1;
        hold(120);

        // clean press and release on channel 0
        pin_v[0] = 1'b0; hold(200);
        pin_v[0] = 1'b1; hold(150);

        // short glitch aborts the check
        pin_v[0] = 1'b0; hold(40);
        pin_v[0] = 1'b1; hold(150);

        // simultaneous press and release on channels 1 and 3
        pin_v[1] = 1'b0; pin_v[3] = 1'b0; hold(150);
        pin_v[1] = 1'b1; pin_v[3] = 1'b1; hold(150);

        // reset in the middle of a check on channel 2
        pin_v[2] = 1'b0; hold(60);
        step(pin_v, 1'b0);
        hold(150);
        pin_v[2] = 1'b1; hold(150);

        // bounce one edge before, on, and one edge after the accepting tick
        race(-1);
        race(0);
        race(1);

        // long holds, released in between to re-arm the long strobe
        pin_v[0] = 1'b0; hold(700);
        pin_v[0] = 1'b1; hold(150);
        pin_v[0] = 1'b0; hold(700);
        pin_v[0] = 1'b1; hold(150);

        // randomized phases of stable, noisy and slowly changing pins
        for (int ph = 0; ph < 30; ph++) begin
            len = $urandom_range(300, 50);
            case ($urandom_range(2, 0))
                0:       rate = 0;
                1:       rate = 8;
                default: rate = 150;
            endcase
            pin_v = CH'($urandom);
            for (int i = 0; i < len; i++) begin
                if (rate != 0) begin
                    for (int c = 0; c < CH; c++) begin
                        if ($urandom_range(rate - 1, 0) == 0) pin_v[c] = ~pin_v[c];
                    end
                end
                rst_bit = ($urandom_range(2999, 0) != 0);
                step(pin_v, rst_bit);
            end
        end

        pin_v = '1;
        hold(200);

        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("st_q_drained", k_m, 32'(st_q.size()), 32'd0);
        check("ev_q_drained", k_m, 32'(ev_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
